// File: rtl/cpu_decode_pipe.sv
// rtl/cpu_decode_pipe.sv - moxie decode stage with valid/ready handshake, skid buffer and flush
module cpu_decode_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 6,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [15:0]           opcode_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OP_WIDTH-1:0]   op_o,
  output logic [3:0]            riA_o,
  output logic [3:0]            riB_o,
  output logic                  register_write_enable_o,
  output logic [3:0]            register_write_index_o,
  output logic [DATA_WIDTH-1:0] operand_o,
  output logic                  illegal_o
);

  // Form-1 ops keep their opcode byte as their code; the holes at 0x0F-0x18
  // (old form-1 branch slots) carry the relocated form-3 branches.
  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_LDI_L  = 6'h01;
  localparam logic [5:0] OP_MOV    = 6'h02;
  localparam logic [5:0] OP_JSRA   = 6'h03;
  localparam logic [5:0] OP_ADD_L  = 6'h05;
  localparam logic [5:0] OP_LDA_L  = 6'h08;
  localparam logic [5:0] OP_STA_L  = 6'h09;
  localparam logic [5:0] OP_LD_L   = 6'h0A;
  localparam logic [5:0] OP_LDO_L  = 6'h0C;
  localparam logic [5:0] OP_STO_L  = 6'h0D;
  localparam logic [5:0] OP_BEQ    = 6'h0F;
  localparam logic [5:0] OP_BLEU   = 6'h18;
  localparam logic [5:0] OP_JMPA   = 6'h1A;
  localparam logic [5:0] OP_LDI_B  = 6'h1B;
  localparam logic [5:0] OP_LD_B   = 6'h1C;
  localparam logic [5:0] OP_LDA_B  = 6'h1D;
  localparam logic [5:0] OP_STA_B  = 6'h1F;
  localparam logic [5:0] OP_LDI_S  = 6'h20;
  localparam logic [5:0] OP_LD_S   = 6'h21;
  localparam logic [5:0] OP_LDA_S  = 6'h22;
  localparam logic [5:0] OP_STA_S  = 6'h24;
  localparam logic [5:0] OP_AND    = 6'h26;
  localparam logic [5:0] OP_LSHR   = 6'h27;
  localparam logic [5:0] OP_ASHL   = 6'h28;
  localparam logic [5:0] OP_SUB_L  = 6'h29;
  localparam logic [5:0] OP_NEG    = 6'h2A;
  localparam logic [5:0] OP_OR     = 6'h2B;
  localparam logic [5:0] OP_NOT    = 6'h2C;
  localparam logic [5:0] OP_ASHR   = 6'h2D;
  localparam logic [5:0] OP_XOR    = 6'h2E;
  localparam logic [5:0] OP_MUL_L  = 6'h2F;
  localparam logic [5:0] OP_SWI    = 6'h30;
  localparam logic [5:0] OP_DIV_L  = 6'h31;
  localparam logic [5:0] OP_UDIV_L = 6'h32;
  localparam logic [5:0] OP_MOD_L  = 6'h33;
  localparam logic [5:0] OP_UMOD_L = 6'h34;
  localparam logic [5:0] OP_LDO_B  = 6'h36;
  localparam logic [5:0] OP_STO_B  = 6'h37;
  localparam logic [5:0] OP_LDO_S  = 6'h38;
  localparam logic [5:0] OP_STO_S  = 6'h39;
  localparam logic [5:0] OP_INC    = 6'h3A;
  localparam logic [5:0] OP_DEC    = 6'h3B;
  localparam logic [5:0] OP_GSR    = 6'h3C;
  localparam logic [5:0] OP_SSR    = 6'h3D;
  localparam logic [5:0] OP_BAD    = 6'h3F;

  typedef struct packed {
    logic [5:0]            op;
    logic [3:0]            ria;
    logic [3:0]            rib;
    logic                  we;
    logic [DATA_WIDTH-1:0] opnd;
  } entry_t;

  entry_t     dec;
  entry_t     main_q;
  logic       main_vld;
  logic [5:0] code;

  // Combinational decode of the presented instruction word into a pipeline entry
  always_comb begin
    dec  = '0;
    code = OP_BAD;
    if (!opcode_i[15]) begin
      if (!opcode_i[14] && (opcode_i[13:8] <= 6'h39) &&
          !((opcode_i[13:8] >= OP_BEQ) && (opcode_i[13:8] <= OP_BLEU)))
        code = opcode_i[13:8];
    end else if (!opcode_i[14]) begin
      code = OP_INC + {4'b0000, opcode_i[13:12]};
    end else if (opcode_i[13:10] <= 4'd9) begin
      code = OP_BEQ + {2'b00, opcode_i[13:10]};
    end
    dec.op  = code;
    dec.ria = opcode_i[15] ? opcode_i[11:8] : opcode_i[7:4];
    dec.rib = opcode_i[3:0];
    case (code)
      OP_LDI_L, OP_LDI_B, OP_LDI_S, OP_MOV, OP_ADD_L, OP_SUB_L, OP_MUL_L,
      OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L,
      OP_LDA_L, OP_LDA_B, OP_LDA_S, OP_LD_L, OP_LD_B, OP_LD_S,
      OP_LDO_L, OP_LDO_B, OP_LDO_S,
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG, OP_LSHR, OP_ASHL, OP_ASHR,
      OP_INC, OP_DEC, OP_GSR:
        dec.we = 1'b1;
      default:
        dec.we = 1'b0;
    endcase
    case (code)
      OP_LDI_L, OP_LDI_B, OP_LDI_S, OP_LDA_L, OP_LDA_B, OP_LDA_S,
      OP_STA_L, OP_STA_B, OP_STA_S, OP_LDO_L, OP_LDO_B, OP_LDO_S,
      OP_STO_L, OP_STO_B, OP_STO_S, OP_JSRA, OP_JMPA, OP_SWI:
        dec.opnd = operand_i;
      OP_INC, OP_DEC, OP_GSR, OP_SSR:
        dec.opnd = {{(DATA_WIDTH-8){1'b0}}, opcode_i[7:0]};
      default: begin
        if ((code >= OP_BEQ) && (code <= OP_BLEU))
          dec.opnd = {{(DATA_WIDTH-11){opcode_i[9]}}, opcode_i[9:0], 1'b0};
        else
          dec.opnd = '0;
      end
    endcase
  end

  if (SKID_EN) begin : g_skid
    entry_t skid_q;
    logic   skid_vld;
    logic   rdy_q;
    logic   in_fire;
    logic   out_fire;

    assign in_fire    = in_valid_i && rdy_q;
    assign out_fire   = main_vld && out_ready_i;
    assign in_ready_o = rdy_q;

    // Main/skid occupancy: a stalled main diverts input to skid, skid refills main on drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        main_q   <= '0;
        main_vld <= 1'b0;
        skid_q   <= '0;
        skid_vld <= 1'b0;
        rdy_q    <= 1'b0;
      end else if (flush_i) begin
        main_q   <= '0;
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
        rdy_q    <= 1'b1;
      end else begin
        if (!main_vld || out_fire) begin
          if (skid_vld) begin
            main_q   <= skid_q;
            main_vld <= 1'b1;
            skid_vld <= 1'b0;
          end else if (in_fire) begin
            main_q   <= dec;
            main_vld <= 1'b1;
          end else begin
            main_vld <= 1'b0;
          end
        end else if (in_fire) begin
          skid_q   <= dec;
          skid_vld <= 1'b1;
        end
        rdy_q <= !(main_vld && !out_fire && (skid_vld || in_fire));
      end
    end
  end else begin : g_single
    assign in_ready_o = !main_vld || out_ready_i;

    // Single output register: reload whenever it is empty or being drained
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        main_q   <= '0;
        main_vld <= 1'b0;
      end else if (flush_i) begin
        main_q   <= '0;
        main_vld <= 1'b0;
      end else if (!main_vld || out_ready_i) begin
        main_vld <= in_valid_i;
        if (in_valid_i)
          main_q <= dec;
      end
    end
  end

  assign out_valid_o             = main_vld;
  assign op_o                    = OP_WIDTH'(main_q.op);
  assign riA_o                   = main_q.ria;
  assign riB_o                   = main_q.rib;
  assign register_write_enable_o = main_q.we;
  assign register_write_index_o  = main_q.ria;
  assign operand_o               = main_q.opnd;
  assign illegal_o               = main_vld && (main_q.op == OP_BAD);

endmodule

// File: tb/tb_cpu_decode_pipe.sv
// tb/tb_cpu_decode_pipe.sv - randomized scoreboard bench for cpu_decode_pipe
module tb_cpu_decode_pipe;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LDI_L = 6'h01;
  localparam logic [5:0] OP_ADD_L = 6'h05;
  localparam logic [5:0] OP_AND   = 6'h26;
  localparam logic [5:0] OP_BEQ   = 6'h0F;
  localparam logic [5:0] OP_BLEU  = 6'h18;
  localparam logic [5:0] OP_INC   = 6'h3A;
  localparam logic [5:0] OP_SSR   = 6'h3D;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  localparam logic [5:0] WE_LIST [31] = '{
    6'h01, 6'h1B, 6'h20, 6'h02, 6'h05, 6'h29, 6'h2F, 6'h31, 6'h32, 6'h33, 6'h34,
    6'h08, 6'h1D, 6'h22, 6'h0A, 6'h1C, 6'h21, 6'h0C, 6'h36, 6'h38,
    6'h26, 6'h2B, 6'h2E, 6'h2C, 6'h2A, 6'h27, 6'h28, 6'h2D,
    6'h3A, 6'h3B, 6'h3C};
  localparam logic [5:0] OPD_LIST [18] = '{
    6'h01, 6'h1B, 6'h20, 6'h08, 6'h1D, 6'h22, 6'h09, 6'h1F, 6'h24,
    6'h0C, 6'h36, 6'h38, 6'h0D, 6'h37, 6'h39, 6'h03, 6'h1A, 6'h30};

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  ria;
    logic [3:0]  rib;
    logic        we;
    logic [31:0] opnd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] opcode = '0;
  logic [31:0] operand = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, we, illegal;
  logic [5:0]  op;
  logic [3:0]  ria, rib, widx;
  logic [31:0] opnd;

  logic        ns_flush = 1'b0;
  logic        ns_in_valid = 1'b0;
  logic [15:0] ns_opcode = '0;
  logic [31:0] ns_operand = '0;
  logic        ns_out_ready = 1'b0;
  logic        ns_in_ready, ns_out_valid, ns_we, ns_illegal;
  logic [5:0]  ns_op;
  logic [3:0]  ns_ria, ns_rib, ns_widx;
  logic [31:0] ns_opnd;

  logic [5:0] ref_op [256];
  logic       we_tbl [64];
  logic       opd_tbl [64];
  exp_t       q[$];
  logic       exp_rdy = 1'b0;
  logic       flushed = 1'b1;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  cpu_decode_pipe #(.DATA_WIDTH(32), .OP_WIDTH(6), .SKID_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .operand_i(operand),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .op_o(op), .riA_o(ria), .riB_o(rib),
    .register_write_enable_o(we), .register_write_index_o(widx),
    .operand_o(opnd), .illegal_o(illegal));

  cpu_decode_pipe #(.DATA_WIDTH(32), .OP_WIDTH(6), .SKID_EN(1'b0)) u_dut_ns (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(ns_flush),
    .in_valid_i(ns_in_valid), .in_ready_o(ns_in_ready),
    .opcode_i(ns_opcode), .operand_i(ns_operand),
    .out_valid_o(ns_out_valid), .out_ready_i(ns_out_ready),
    .op_o(ns_op), .riA_o(ns_ria), .riB_o(ns_rib),
    .register_write_enable_o(ns_we), .register_write_index_o(ns_widx),
    .operand_o(ns_opnd), .illegal_o(ns_illegal));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void build_tables();
    for (int i = 0; i < 64; i++) begin
      we_tbl[i]  = 1'b0;
      opd_tbl[i] = 1'b0;
    end
    foreach (WE_LIST[i]) we_tbl[WE_LIST[i]] = 1'b1;
    foreach (OPD_LIST[i]) opd_tbl[OPD_LIST[i]] = 1'b1;
    for (int b = 0; b < 256; b++) begin
      if (b < 128) begin
        if (b <= 'h39 && !(b >= 'h0F && b <= 'h18)) ref_op[b] = 6'(b);
        else ref_op[b] = OP_BAD;
      end else if (b < 192) begin
        ref_op[b] = OP_INC + 6'((b - 128) / 16);
      end else begin
        ref_op[b] = (((b - 192) / 4) < 10) ? OP_BEQ + 6'((b - 192) / 4) : OP_BAD;
      end
    end
  endfunction

  function automatic exp_t ref_decode(input logic [15:0] opc, input logic [31:0] opd);
    exp_t e;
    int   off;
    e.op  = ref_op[int'(opc[15:8])];
    e.ria = opc[15] ? opc[11:8] : opc[7:4];
    e.rib = opc[3:0];
    e.we  = we_tbl[e.op];
    if (opd_tbl[e.op]) begin
      e.opnd = opd;
    end else if (e.op >= OP_INC && e.op <= OP_SSR) begin
      e.opnd = {24'h0, opc[7:0]};
    end else if (e.op >= OP_BEQ && e.op <= OP_BLEU) begin
      off = int'(opc[9:0]);
      if (off >= 512) off = off - 1024;
      e.opnd = 32'(off * 2);
    end else begin
      e.opnd = 32'h0;
    end
    return e;
  endfunction

  task automatic compare_model();
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (q.size() > 0) begin
      check("op", 64'(op), 64'(q[0].op));
      check("riA", 64'(ria), 64'(q[0].ria));
      check("riB", 64'(rib), 64'(q[0].rib));
      check("we", 64'(we), 64'(q[0].we));
      check("widx", 64'(widx), 64'(q[0].ria));
      check("operand", 64'(opnd), 64'(q[0].opnd));
      check("illegal", 64'(illegal), 64'(q[0].op == OP_BAD));
    end else begin
      check("illegal_idle", 64'(illegal), 64'(0));
      if (flushed) check("op_cleared", 64'(op), 64'(OP_NOP));
    end
  endtask

  // Called at a negedge; drives one cycle of stimulus and compares after the edge.
  task automatic step(input logic v, input logic [15:0] opc, input logic [31:0] opd,
                      input logic ordy, input logic fl);
    exp_t e;
    logic in_fire, out_fire;
    in_valid  = v;
    opcode    = opc;
    operand   = opd;
    out_ready = ordy;
    flush     = fl;
    in_fire   = v && exp_rdy;
    out_fire  = (q.size() > 0) && ordy;
    e = ref_decode(opc, opd);
    @(posedge clk);
    if (fl) begin
      q.delete();
      flushed = 1'b1;
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        q.push_back(e);
        flushed = 1'b0;
      end
    end
    exp_rdy = (q.size() < 2);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    logic [7:0] bb;
    build_tables();

    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_op", 64'(op), 64'(OP_NOP));
    check("rst_operand", 64'(opnd), 64'(0));
    check("rst_we", 64'(we), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_rdy = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    compare_model();

    // LDI.L with trailing word
    step(1'b1, 16'h0112, 32'hDEADBEEF, 1'b1, 1'b0);
    check("ldi_op", 64'(op), 64'(OP_LDI_L));
    check("ldi_riA", 64'(ria), 64'(1));
    check("ldi_riB", 64'(rib), 64'(2));
    check("ldi_we", 64'(we), 64'(1));
    check("ldi_widx", 64'(widx), 64'(1));
    check("ldi_operand", 64'(opnd), 64'(32'hDEADBEEF));

    // INC and branch immediates
    step(1'b1, 16'h8A05, 32'h12345678, 1'b1, 1'b0);
    check("inc_op", 64'(op), 64'(OP_INC));
    check("inc_riA", 64'(ria), 64'(4'hA));
    check("inc_operand", 64'(opnd), 64'(32'h5));
    check("inc_we", 64'(we), 64'(1));
    step(1'b1, 16'hC3FF, 32'h12345678, 1'b1, 1'b0);
    check("beq_op", 64'(op), 64'(OP_BEQ));
    check("beq_operand", 64'(opnd), 64'(32'hFFFFFFFE));
    check("beq_we", 64'(we), 64'(0));
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure through the skid buffer
    step(1'b1, 16'h0112, 32'hA1, 1'b0, 1'b0);
    check("bp_ready_after_first", 64'(in_ready), 64'(1));
    step(1'b1, 16'h0534, 32'hA2, 1'b0, 1'b0);
    check("bp_ready_after_second", 64'(in_ready), 64'(0));
    step(1'b1, 16'h2678, 32'hA3, 1'b0, 1'b0);
    check("bp_held_op", 64'(op), 64'(OP_LDI_L));
    step(1'b1, 16'h2678, 32'hA3, 1'b1, 1'b0);
    check("bp_second_op", 64'(op), 64'(OP_ADD_L));
    step(1'b1, 16'h2678, 32'hA3, 1'b1, 1'b0);
    check("bp_third_op", 64'(op), 64'(OP_AND));
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    check("bp_drained", 64'(out_valid), 64'(0));

    // Flush with both entries full and a simultaneous input
    step(1'b1, 16'h0112, 32'hB1, 1'b0, 1'b0);
    step(1'b1, 16'h0534, 32'hB2, 1'b0, 1'b0);
    step(1'b1, 16'h2678, 32'hB3, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_op", 64'(op), 64'(OP_NOP));
    repeat (3) step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream with two entries held
    step(1'b1, 16'h0112, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 16'h0534, 32'hC2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_op", 64'(op), 64'(OP_NOP));
    q.delete();
    flushed = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_rdy = 1'b1;
    check("midrst_ready", 64'(in_ready), 64'(1));
    compare_model();

    // Sweep every opcode byte
    for (int b = 0; b < 256; b++) begin
      bb = 8'(b);
      step(1'b1, {bb, 8'($urandom)}, $urandom, 1'b1, 1'b0);
      if (bb == 8'h10 || bb == 8'hE8) begin
        check("sweep_illegal", 64'(illegal), 64'(1));
        check("sweep_bad_we", 64'(we), 64'(0));
      end
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

    // Single-register variant: ready drops after the first held word
    ns_out_ready = 1'b0;
    ns_in_valid  = 1'b1;
    ns_opcode    = 16'h0112;
    ns_operand   = 32'h11;
    @(posedge clk);
    @(negedge clk);
    check("ns_valid", 64'(ns_out_valid), 64'(1));
    check("ns_first_op", 64'(ns_op), 64'(OP_LDI_L));
    check("ns_ready_drop", 64'(ns_in_ready), 64'(0));
    ns_opcode  = 16'h0534;
    ns_operand = 32'h22;
    @(posedge clk);
    @(negedge clk);
    check("ns_stable_op", 64'(ns_op), 64'(OP_LDI_L));
    check("ns_stable_operand", 64'(ns_opnd), 64'(32'h11));
    ns_out_ready = 1'b1;
    #1;
    check("ns_ready_comb", 64'(ns_in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    check("ns_second_op", 64'(ns_op), 64'(OP_ADD_L));
    check("ns_second_valid", 64'(ns_out_valid), 64'(1));
    ns_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ns_drained", 64'(ns_out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_decode_pipe.md
Name: cpu_decode_pipe

Overview:
- Parametrised successor decode stage for the moxie core.
- Sits between fetch and execute. Decodes the moxie 16-bit opcode (forms 1, 2 and 3) into `OP_*` codes, register indices, write-enable and an extended immediate.
- Adds a valid/ready handshake with a 2-entry skid buffer, flush, illegal-opcode flagging, and decode-time immediate extension (INC/DEC, GSR/SSR, branch offsets).

Parameters:
- DATA_WIDTH, 32, width of operand_i/operand_o; must be >= 16.
- OP_WIDTH, 6, width of op_o; must hold every `OP_*` code in defines.v.
- SKID_EN, 1, 1 = 2-entry skid buffer (full throughput under backpressure); 0 = single output register, in_ready_o = !out_valid_o || out_ready_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all held entries this cycle.
- in_valid_i  in  1  opcode_i/operand_i valid.
- in_ready_o  out  1  stage can accept.
- opcode_i  in  16  instruction word.
- operand_i  in  DATA_WIDTH  trailing 32-bit word, when present.
- out_valid_o  out  1  decoded entry valid.
- out_ready_i  in  1  execute accepts.
- op_o  out  OP_WIDTH  `OP_*` code.
- riA_o  out  4  register A index.
- riB_o  out  4  register B index.
- register_write_enable_o  out  1  instruction writes riA.
- register_write_index_o  out  4  equals riA_o.
- operand_o  out  DATA_WIDTH  extended immediate/operand.
- illegal_o  out  1  entry is OP_BAD.

Behaviour:
- Reset (async assert, sync deassert):
  - out_valid_o=0, op_o=`OP_NOP`, all other outputs 0.
  - Skid buffer empty; in_ready_o=1 one cycle after deassert.
- Transfer:
  - In on in_valid_i && in_ready_o; out on out_valid_o && out_ready_i.
  - Latency 1 cycle from input transfer to out_valid_o.
  - Outputs stable while out_valid_o && !out_ready_i.
- Skid (SKID_EN=1):
  - Main register plus skid register; in_ready_o = skid empty (registered).
  - Input accepted while main is stalled goes to skid. On out transfer, skid moves to main.
  - Order is strictly preserved. Simultaneous in/out transfer with skid empty: main replaced, no bubble.
- Flush:
  - flush_i clears both entries next edge: out_valid_o=0, op_o=`OP_NOP`.
  - An input presented the same cycle is dropped.
  - Flush dominates a simultaneous transfer.
- Index decode:
  - Form 1 (opcode[15]=0): riA=opcode[7:4], riB=opcode[3:0].
  - Forms 2/3 (opcode[15]=1): riA=opcode[11:8], riB=opcode[3:0].
  - register_write_index_o always equals riA_o.
- Opcode map: opcode[15:8] maps to `OP_*` per the moxie ISA in defines.v.
  - Form 1 0x00–0x39 named ops; 0x0F–0x18 and 0x3A–0x3F → `OP_BAD`.
  - 1000=INC, 1001=DEC, 1010=GSR, 1011=SSR.
  - 110000..111001 = BEQ, BNE, BLT, BGT, BLTU, BGTU, BGE, BLE, BGEU, BLEU; 111010..111111 → `OP_BAD`.
- Write enable = 1 exactly for:
  - LDI_L/B/S, MOV, ADD_L, SUB_L, MUL_L, DIV_L, UDIV_L, MOD_L, UMOD_L;
  - LDA_L/B/S, LD_L/B/S, LDO_L/B/S;
  - AND, OR, XOR, NOT, NEG, LSHR, ASHL, ASHR;
  - INC, DEC, GSR.
  - 0 otherwise, including NOP, BAD, POP. POP's second write is execute's concern.
- Operand:
  - LDI_*, LDA_*, STA_*, LDO_*, STO_*, JSRA, JMPA, SWI: operand_i.
  - INC/DEC: zero-extended opcode[7:0].
  - GSR/SSR: zero-extended opcode[7:0].
  - Branches: sign-extended {opcode[9:0],1'b0}.
  - Else 0.
- illegal_o = (op_o==`OP_BAD`) && out_valid_o. An illegal entry still flows with write enable 0.
- Entries with in_valid_i=0 are never captured; no X propagation into held registers.

Test Plan:
- Reset low mid-stream with entries held → out_valid_o=0, op_o=`OP_NOP` immediately. After release, in_ready_o=1 next cycle.
- opcode 0x0112, operand 0xDEADBEEF, out_ready_i=1 → next cycle: `OP_LDI_L`, riA=1, riB=2, write enable=1, index=1, operand 0xDEADBEEF.
- INC/branch immediates:
  - 0x8A05 → `OP_INC`, riA=0xA, operand 0x00000005, write enable 1.
  - 0xC3FF → `OP_BEQ`, operand 0xFFFFFFFE, write enable 0.
- Backpressure: out_ready_i=0, send 0x0112 then 0x0534 → in_ready_o drops after the second; a third word is held. Raise out_ready_i → order LDI_L, ADD_L, third, with no loss or duplicate. Repeat with SKID_EN=0: in_ready_o drops after the first.
- flush_i with both entries full plus a simultaneous input → next cycle out_valid_o=0, and nothing from the three ever appears.
- Sweep all 256 values of opcode[15:8] → op_o/write enable/illegal_o match the map. 0x10 and 0xE8 give illegal_o=1 and write enable 0.
